// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
// ---------------------------------------------------------------------------
// Expands a Load-Multiple (LM, 4'b0110) or Store-Multiple (SM, 4'b0111)
// instruction into single-register LW/SW-type micro-ops. It emits one
// micro-op per cycle, in ascending register order. While a sequence runs it
// holds fetch and decode.
//
// Optional feature: define LMSM_BASE_WRITEBACK_EN to add a final WB micro-op.
// That micro-op writes Ra + transfer count back into Ra. When the macro is
// not defined there is no WB state, and uop_wb_base is tied low.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   flush         abort the current sequence (branch/jump redirect)
//   stall_in      downstream cannot take a micro-op this cycle
//   instr_valid   a valid instruction is in decode
//   opcode        instruction opcode
//   ra            base register index
//   reg_mask      register list, bit i selects Ri
//   busy          registered, high while the sequencer is not idle
//   fetch_hold    freezes PC and IF/ID (accept | (busy & !done))
//   uop_valid     micro-op presented this cycle
//   uop_is_store  1 = SW-type micro-op, 0 = LW-type
//   uop_reg       data register of the micro-op (base register for WB)
//   uop_base      captured Ra
//   uop_off       address offset added to Ra (transfer count for WB)
//   uop_wb_base   micro-op is the base-register writeback
//   done          single-cycle completion pulse
// ---------------------------------------------------------------------------
module lm_sm_sequencer #(
  parameter int NREGS = 8,
  parameter int OFF_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall_in,
  input  logic             instr_valid,
  input  logic [3:0]       opcode,
  input  logic [2:0]       ra,
  input  logic [NREGS-1:0] reg_mask,
  output logic             busy,
  output logic             fetch_hold,
  output logic             uop_valid,
  output logic             uop_is_store,
  output logic [2:0]       uop_reg,
  output logic [2:0]       uop_base,
  output logic [OFF_W-1:0] uop_off,
  output logic             uop_wb_base,
  output logic             done
);

  localparam logic [3:0]       OP_LM   = 4'b0110;
  localparam logic [3:0]       OP_SM   = 4'b0111;
  localparam logic [OFF_W-1:0] OFF_MAX = {OFF_W{1'b1}};

`ifdef LMSM_BASE_WRITEBACK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_EMPTY = 2'd2,
    ST_WB    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_EMPTY = 2'd2
  } state_t;
`endif

  // Index of the lowest set bit. The scan runs downward so that the lowest
  // set bit is the last one written.
  function automatic logic [2:0] lowest_set(input logic [NREGS-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t             state_r, state_s;
  logic [NREGS-1:0]   mask_r, mask_s;
  logic [OFF_W-1:0]   off_r, off_s;
  logic [2:0]         base_r, base_s;
  logic               is_store_r, is_store_s;
  logic               busy_r;

  logic               is_lmsm_s;
  logic               accept_s;
  logic               last_s;
  logic [NREGS-1:0]   mask_clr_s;
  logic [OFF_W-1:0]   off_inc_s;
  logic               uop_valid_s, uop_is_store_s, uop_wb_base_s, done_s;
  logic [2:0]         uop_reg_s, uop_base_s;
  logic [OFF_W-1:0]   uop_off_s;

  // State and captured-operand registers, plus the registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mask_r     <= {NREGS{1'b0}};
      off_r      <= {OFF_W{1'b0}};
      base_r     <= 3'd0;
      is_store_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      mask_r     <= mask_s;
      off_r      <= off_s;
      base_r     <= base_s;
      is_store_r <= is_store_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  // Next-state, operand update and micro-op decode.
  always_comb begin
    state_s        = state_r;
    mask_s         = mask_r;
    off_s          = off_r;
    base_s         = base_r;
    is_store_s     = is_store_r;
    accept_s       = 1'b0;
    uop_valid_s    = 1'b0;
    uop_is_store_s = 1'b0;
    uop_reg_s      = 3'd0;
    uop_base_s     = 3'd0;
    uop_off_s      = {OFF_W{1'b0}};
    uop_wb_base_s  = 1'b0;
    done_s         = 1'b0;

    is_lmsm_s  = (opcode == OP_LM) || (opcode == OP_SM);
    // Clearing the lowest set bit. If the result is zero, the current bit
    // was the last one.
    mask_clr_s = mask_r & (mask_r - {{(NREGS-1){1'b0}}, 1'b1});
    last_s     = (mask_clr_s == {NREGS{1'b0}});
    off_inc_s  = (off_r == OFF_MAX) ? off_r : (off_r + {{(OFF_W-1){1'b0}}, 1'b1});

    case (state_r)
      ST_IDLE: begin
        if (instr_valid && is_lmsm_s && !flush) begin
          accept_s   = 1'b1;
          is_store_s = opcode[0];
          base_s     = ra;
          mask_s     = reg_mask;
          off_s      = {OFF_W{1'b0}};
          if (reg_mask != {NREGS{1'b0}}) begin
            state_s = ST_XFER;
          end else begin
`ifdef LMSM_BASE_WRITEBACK_EN
            state_s = ST_WB;
`else
            state_s = ST_EMPTY;
`endif
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_XFER: begin
        uop_valid_s    = 1'b1;
        uop_is_store_s = is_store_r;
        uop_reg_s      = lowest_set(mask_r);
        uop_base_s     = base_r;
        uop_off_s      = off_r;
        if (!stall_in) begin
          mask_s = mask_clr_s;
          off_s  = off_inc_s;
          if (last_s) begin
`ifdef LMSM_BASE_WRITEBACK_EN
            state_s = ST_WB;
`else
            state_s = ST_IDLE;
            done_s  = 1'b1;
`endif
          end else begin
            state_s = ST_XFER;
          end
        end else begin
          state_s = ST_XFER;
        end
      end

      ST_EMPTY: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

`ifdef LMSM_BASE_WRITEBACK_EN
      // The writeback micro-op carries the base register and the total count.
      ST_WB: begin
        uop_valid_s   = 1'b1;
        uop_wb_base_s = 1'b1;
        uop_reg_s     = base_r;
        uop_base_s    = base_r;
        uop_off_s     = off_r;
        if (!stall_in) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WB;
        end
      end
`endif

      default: begin
        state_s = ST_IDLE;
        mask_s  = {NREGS{1'b0}};
        off_s   = {OFF_W{1'b0}};
      end
    endcase

    // A redirect overrides everything and never produces a done pulse.
    if (flush) begin
      state_s = ST_IDLE;
      mask_s  = {NREGS{1'b0}};
      off_s   = {OFF_W{1'b0}};
      done_s  = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  assign busy         = busy_r;
  assign fetch_hold   = accept_s | (busy_r & ~done_s);
  assign uop_valid    = uop_valid_s;
  assign uop_is_store = uop_is_store_s;
  assign uop_reg      = uop_reg_s;
  assign uop_base     = uop_base_s;
  assign uop_off      = uop_off_s;
`ifdef LMSM_BASE_WRITEBACK_EN
  assign uop_wb_base  = uop_wb_base_s;
`else
  assign uop_wb_base  = 1'b0;
`endif
  assign done         = done_s;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
`timescale 1ns/1ps
module tb_lm_sm_sequencer;

  localparam int NREGS = 8;
  localparam int OFF_W = 4;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;
`ifdef LMSM_BASE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             stall_in = 1'b0;
  logic             instr_valid = 1'b0;
  logic [3:0]       opcode = 4'd0;
  logic [2:0]       ra = 3'd0;
  logic [NREGS-1:0] reg_mask = '0;
  logic             busy, fetch_hold, uop_valid, uop_is_store, uop_wb_base, done;
  logic [2:0]       uop_reg, uop_base;
  logic [OFF_W-1:0] uop_off;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [2:0] r;
    logic [3:0] off;
    logic       wb;
  } uop_t;

  always #5 clk = ~clk;

  lm_sm_sequencer #(.NREGS(NREGS), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall_in(stall_in),
    .instr_valid(instr_valid), .opcode(opcode), .ra(ra), .reg_mask(reg_mask),
    .busy(busy), .fetch_hold(fetch_hold), .uop_valid(uop_valid),
    .uop_is_store(uop_is_store), .uop_reg(uop_reg), .uop_base(uop_base),
    .uop_off(uop_off), .uop_wb_base(uop_wb_base), .done(done)
  );

  // Observation vector: valid,store,reg,base,off,wb,done,fetch_hold,busy
  function automatic logic [15:0] obs();
    return {uop_valid, uop_is_store, uop_reg, uop_base, uop_off, uop_wb_base,
            done, fetch_hold, busy};
  endfunction

  function automatic logic [15:0] ev(input logic v, input logic st,
                                     input logic [2:0] r, input logic [2:0] b,
                                     input logic [3:0] o, input logic wb,
                                     input logic d, input logic fh, input logic bz);
    return {v, st, r, b, o, wb, d, fh, bz};
  endfunction

  // Drive point: just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; stall_in = 1'b0; instr_valid = 1'b0;
    opcode = 4'd0; ra = 3'd0; reg_mask = '0;
  endtask

  task automatic test_reset();
    logic [15:0] o;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    o = obs();
    if (o !== 16'h0000) $display("FAIL reset_values: got %h expected %h", o, 16'h0000);
    else passes++;
    checks++;
    step(); rst_n = 1'b1;
    step(); instr_valid = 1'b1; opcode = OP_LM; ra = 3'd5; reg_mask = 8'hFF;
    step(); instr_valid = 1'b0;
    step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 o = obs();
    if (o !== 16'h0000) $display("FAIL reset_async: got %h expected %h", o, 16'h0000);
    else passes++;
    checks++;
    step(); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      o = obs();
      if (o !== 16'h0000) $display("FAIL reset_no_uops cycle %0d: got %h expected %h", c, o, 16'h0000);
      else passes++;
      checks++;
      step();
    end
  endtask

  task automatic test_lm_directed();
    logic [2:0]  exp_reg [4];
    logic [15:0] o, e;
    logic        d;
    exp_reg = '{3'd0, 3'd2, 3'd5, 3'd7};
    idle_inputs();
    instr_valid = 1'b1; opcode = OP_LM; ra = 3'd3; reg_mask = 8'b1010_0101;
    @(negedge clk);
    o = obs(); e = ev(0, 0, 0, 0, 0, 0, 0, 1, 0);
    if (o !== e) $display("FAIL lm_accept: got %h expected %h", o, e);
    else passes++;
    checks++;
    for (int k = 0; k < 4; k++) begin
      step(); instr_valid = 1'b0;
      @(negedge clk);
      d = (k == 3) && !WB_EN;
      o = obs(); e = ev(1, 0, exp_reg[k], 3'd3, 4'(k), 0, d, !d, 1);
      if (o !== e) $display("FAIL lm_uop%0d: got %h expected %h", k, o, e);
      else passes++;
      checks++;
    end
`ifdef LMSM_BASE_WRITEBACK_EN
    step();
    @(negedge clk);
    o = obs(); e = ev(1, 0, 3'd3, 3'd3, 4'd4, 1, 1, 0, 1);
    if (o !== e) $display("FAIL lm_wb: got %h expected %h", o, e);
    else passes++;
    checks++;
`endif
    step();
    @(negedge clk);
    o = obs();
    if (o !== 16'h0000) $display("FAIL lm_after_done: got %h expected %h", o, 16'h0000);
    else passes++;
    checks++;
  endtask

  task automatic test_stall_sm();
    logic        stall_tab [4];
    logic [2:0]  reg_tab [4];
    logic [15:0] o, e;
    logic        d;
    int          done_cnt;
    stall_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
    reg_tab   = '{3'd0, 3'd0, 3'd0, 3'd1};
    done_cnt  = 0;
    step(); idle_inputs();
    instr_valid = 1'b1; opcode = OP_SM; ra = 3'd4; reg_mask = 8'b0000_0011;
    for (int k = 0; k < 4; k++) begin
      step(); instr_valid = 1'b0; stall_in = stall_tab[k];
      @(negedge clk);
      done_cnt += int'(done);
      d = (k == 3) && !WB_EN;
      o = obs(); e = ev(1, 1, reg_tab[k], 3'd4, {1'b0, reg_tab[k]}, 0, d, !d, 1);
      if (o !== e) $display("FAIL sm_stall cycle %0d: got %h expected %h", k + 1, o, e);
      else passes++;
      checks++;
    end
    stall_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      done_cnt += int'(done);
    end
    if (done_cnt !== 1) $display("FAIL sm_done_once: got %0d pulses expected 1", done_cnt);
    else passes++;
    checks++;
  endtask

  task automatic test_empty();
    logic [15:0] o, e;
    step(); idle_inputs();
    instr_valid = 1'b1; opcode = OP_LM; ra = 3'd6; reg_mask = 8'h00;
    @(negedge clk);
    o = obs(); e = ev(0, 0, 0, 0, 0, 0, 0, 1, 0);
    if (o !== e) $display("FAIL empty_accept: got %h expected %h", o, e);
    else passes++;
    checks++;
    step(); instr_valid = 1'b0;
    @(negedge clk);
`ifdef LMSM_BASE_WRITEBACK_EN
    e = ev(1, 0, 3'd6, 3'd6, 4'd0, 1, 1, 0, 1);
`else
    e = ev(0, 0, 0, 0, 0, 0, 1, 0, 1);
`endif
    o = obs();
    if (o !== e) $display("FAIL empty_cycle: got %h expected %h", o, e);
    else passes++;
    checks++;
    step();
    @(negedge clk);
    o = obs();
    if (o !== 16'h0000) $display("FAIL empty_after: got %h expected %h", o, 16'h0000);
    else passes++;
    checks++;
  endtask

  task automatic test_flush();
    logic [15:0] o, e;
    step(); idle_inputs();
    instr_valid = 1'b1; opcode = OP_LM; ra = 3'd2; reg_mask = 8'hFF;
    step(); instr_valid = 1'b0;
    step();
    step(); flush = 1'b1;
    @(negedge clk);
    o = obs(); e = ev(1, 0, 3'd2, 3'd2, 4'd2, 0, 0, 1, 1);
    if (o !== e) $display("FAIL flush_third_uop: got %h expected %h", o, e);
    else passes++;
    checks++;
    step(); flush = 1'b0;
    @(negedge clk);
    o = obs();
    if (o !== 16'h0000) $display("FAIL flush_idle: got %h expected %h", o, 16'h0000);
    else passes++;
    checks++;
    step(); instr_valid = 1'b1; opcode = OP_LM; ra = 3'd1; reg_mask = 8'b0001_1000;
    @(negedge clk);
    o = obs(); e = ev(0, 0, 0, 0, 0, 0, 0, 1, 0);
    if (o !== e) $display("FAIL flush_reaccept: got %h expected %h", o, e);
    else passes++;
    checks++;
    step(); instr_valid = 1'b0;
    @(negedge clk);
    o = obs(); e = ev(1, 0, 3'd3, 3'd1, 4'd0, 0, 0, 1, 1);
    if (o !== e) $display("FAIL flush_restart_off0: got %h expected %h", o, e);
    else passes++;
    checks++;
    step(); flush = 1'b1;
    step(); flush = 1'b1; instr_valid = 1'b1; opcode = OP_SM; reg_mask = 8'hFF;
    @(negedge clk);
    o = obs();
    if (o !== 16'h0000) $display("FAIL flush_blocks_accept: got %h expected %h", o, 16'h0000);
    else passes++;
    checks++;
    step(); flush = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    o = obs();
    if (o !== 16'h0000) $display("FAIL flush_no_start: got %h expected %h", o, 16'h0000);
    else passes++;
    checks++;
  endtask

  task automatic test_random();
    uop_t        q[$];
    uop_t        u;
    logic [15:0] o, e;
    logic [3:0]  op;
    logic [7:0]  m;
    logic [2:0]  b;
    logic        lmsm, st, d;
    int          sel, cnt, cyc;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) op = OP_LM;
      else if (sel < 8) op = OP_SM;
      else begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_LM || op == OP_SM) op = 4'b1111;
      end
      sel = $urandom_range(0, 7);
      m = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      b = 3'($urandom);
      lmsm = (op == OP_LM) || (op == OP_SM);
      st = op[0];
      // Reference: one micro-op per set bit, ascending, offset = ordinal.
      q.delete();
      cnt = 0;
      for (int i = 0; i < NREGS; i++) begin
        if (m[i]) begin
          u.r = 3'(i); u.off = 4'(cnt); u.wb = 1'b0;
          q.push_back(u);
          cnt++;
        end
      end
      if (WB_EN) begin
        u.r = b; u.off = 4'(cnt); u.wb = 1'b1;
        q.push_back(u);
      end
      step();
      instr_valid = 1'b1; opcode = op; ra = b; reg_mask = m; stall_in = 1'($urandom);
      @(negedge clk);
      o = obs();
      e = lmsm ? ev(0, 0, 0, 0, 0, 0, 0, 1, 0) : 16'h0000;
      if (o !== e) $display("FAIL rand_accept t%0d: got %h expected %h", t, o, e);
      else passes++;
      checks++;
      if (!lmsm) continue;
      if (q.size() == 0) begin
        step(); instr_valid = 1'($urandom); opcode = OP_LM; stall_in = 1'($urandom);
        @(negedge clk);
        o = obs(); e = ev(0, 0, 0, 0, 0, 0, 1, 0, 1);
        if (o !== e) $display("FAIL rand_empty t%0d: got %h expected %h", t, o, e);
        else passes++;
        checks++;
      end
      cyc = 0;
      while (q.size() != 0 && cyc < 64) begin
        step();
        instr_valid = 1'($urandom); opcode = OP_LM;
        stall_in = ($urandom_range(0, 9) < 3);
        @(negedge clk);
        u = q[0];
        d = !stall_in && (q.size() == 1);
        o = obs();
        e = ev(1, u.wb ? 1'b0 : st, u.r, b, u.off, u.wb, d, !d, 1);
        if (o !== e) $display("FAIL rand_uop t%0d cyc %0d: got %h expected %h", t, cyc, o, e);
        else passes++;
        checks++;
        if (!stall_in) void'(q.pop_front());
        cyc++;
      end
      if (q.size() != 0) begin
        $display("FAIL rand_timeout t%0d: %0d micro-ops left, expected 0", t, q.size());
        checks++;
      end
      step(); instr_valid = 1'b0; stall_in = 1'b0;
      @(negedge clk);
      o = obs();
      if (o !== 16'h0000) $display("FAIL rand_idle t%0d: got %h expected %h", t, o, 16'h0000);
      else passes++;
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_lm_directed();
    test_stall_sm();
    test_empty();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
